// File: rtl/frame_filter_sequencer.sv
// rtl/frame_filter_sequencer.sv - frame sequencer sharing InputMemory between pixel loader and window generator
module frame_filter_sequencer #(
    parameter int IMG_W   = 480,
    parameter int IMG_H   = 272,
    parameter int ADDR_W  = 17,
    parameter int PIX_W   = 24,
    parameter int CNT_W   = 17,
    parameter int TIMEOUT = 4096
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              ld_valid,
    input  logic [PIX_W-1:0]  ld_data,
    output logic              ld_ready,
    input  logic              win_bram_en,
    input  logic [ADDR_W-1:0] win_bram_addr,
    input  logic              win_o_valid,
    input  logic              win_o_ready,
    input  logic              win_frame_done,
    output logic              win_rst_n,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_din,
    output logic              busy,
    output logic              done,
    output logic              err_count,
    output logic              err_timeout,
    output logic [CNT_W-1:0]  win_count
);
    localparam int                WD_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  N_PIX     = CNT_W'(IMG_W * IMG_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [PIX_W-1:0]    r_mem_din;
    logic                r_wr_pend;
    logic                r_win_rst_n;
    logic                r_done;
    logic                r_err_count;
    logic                r_err_timeout;
    logic [CNT_W-1:0]    r_win_count;
    logic [WD_W-1:0]     r_wdog;

    logic                w_read_path;
    logic                w_wdog_hit;
    logic [CNT_W-1:0]    w_win_cnt_next;
    logic                w_unused_ready;

    assign w_unused_ready = win_o_ready;
    assign w_win_cnt_next = r_win_count + CNT_W'(win_o_valid);
    assign w_wdog_hit     = (r_wdog == WD_LAST) && !win_o_valid;

    // Reads pass straight through: the window generator's capture pipeline expects raw BRAM timing.
    assign w_read_path = (r_state == S_RUN) && !r_wr_pend;
    assign mem_en      = r_wr_pend ? !abort : (w_read_path && win_bram_en);
    assign mem_we      = r_wr_pend && !abort;
    assign mem_addr    = w_read_path ? win_bram_addr : r_mem_addr;
    assign mem_din     = r_mem_din;

    assign ld_ready    = (r_state == S_LOAD);
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign win_rst_n   = r_win_rst_n;
    assign err_count   = r_err_count;
    assign err_timeout = r_err_timeout;
    assign win_count   = r_win_count;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state       <= S_IDLE;
            r_wr_addr     <= '0;
            r_mem_addr    <= '0;
            r_mem_din     <= '0;
            r_wr_pend     <= 1'b0;
            r_win_rst_n   <= 1'b0;
            r_done        <= 1'b0;
            r_err_count   <= 1'b0;
            r_err_timeout <= 1'b0;
            r_win_count   <= '0;
            r_wdog        <= '0;
        end else begin
            r_wr_pend <= 1'b0;
            r_done    <= 1'b0;
            if (abort) begin
                r_state     <= S_IDLE;
                r_win_rst_n <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_win_rst_n <= 1'b0;
                        if (start) begin
                            r_win_count   <= '0;
                            r_err_count   <= 1'b0;
                            r_err_timeout <= 1'b0;
                            r_wr_addr     <= '0;
                            r_state       <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (ld_valid) begin
                            r_wr_pend  <= 1'b1;
                            r_mem_addr <= r_wr_addr;
                            r_mem_din  <= ld_data;
                            r_wr_addr  <= r_wr_addr + ADDR_W'(1);
                            // The last pixel's write lands in the first RUN cycle, before win_rst_n releases.
                            if (r_wr_addr == LAST_ADDR) begin
                                r_state <= S_RUN;
                                r_wdog  <= '0;
                            end
                        end
                    end
                    S_RUN: begin
                        r_win_count <= w_win_cnt_next;
                        r_wdog      <= win_o_valid ? '0 : r_wdog + WD_W'(1);
                        if (win_frame_done) begin
                            r_err_count <= (w_win_cnt_next != N_PIX);
                            r_done      <= 1'b1;
                            r_win_rst_n <= 1'b0;
                            r_state     <= S_DONE;
                        end else if (w_wdog_hit) begin
                            r_err_timeout <= 1'b1;
                            r_done        <= 1'b1;
                            r_win_rst_n   <= 1'b0;
                            r_state       <= S_DONE;
                        end else begin
                            r_win_rst_n <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_win_rst_n <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/frame_filter_sequencer.md
Name: frame_filter_sequencer

Overview:
- Frame-level controller for the filtering pipeline.
- Owns the single port of InputMemory and shares it between two requesters:
  - a streaming pixel loader, which writes the image;
  - the 3x3 window generator, which reads it.
- Sequences each frame through LOAD -> RUN -> DONE.
- Holds the window generator in reset outside RUN, counts emitted windows, and flags count mismatches and stalls.

Parameters:
- IMG_W, 480, image width in pixels
- IMG_H, 272, image height in pixels
- ADDR_W, 17, InputMemory address width
- PIX_W, 24, pixel width
- CNT_W, 17, width of pixel/window counters (must hold IMG_W*IMG_H)
- TIMEOUT, 4096, maximum RUN cycles allowed between window handshakes

Ports:
- iClk  in  1  clock
- iRst_n  in  1  async active-low reset
- start  in  1  single-cycle pulse that begins a frame; honoured only in IDLE
- abort  in  1  synchronous abort; returns to IDLE from any state
- ld_valid  in  1  loader pixel valid
- ld_data  in  PIX_W  loader pixel
- ld_ready  out  1  sequencer accepts a loader pixel
- win_bram_en  in  1  window generator read enable
- win_bram_addr  in  ADDR_W  window generator read address
- win_o_valid  in  1  window generator output valid
- win_o_ready  in  1  consumer ready, observed only
- win_frame_done  in  1  window generator end-of-frame pulse
- win_rst_n  out  1  synchronous active-low reset to the window generator
- mem_en  out  1  InputMemory enable
- mem_we  out  1  InputMemory write enable
- mem_addr  out  ADDR_W  InputMemory address
- mem_din  out  PIX_W  InputMemory write data
- busy  out  1  high in LOAD, RUN and DONE
- done  out  1  one-cycle pulse at end of frame
- err_count  out  1  sticky: window count is not IMG_W*IMG_H at frame end
- err_timeout  out  1  sticky: watchdog expired
- win_count  out  CNT_W  number of windows emitted in the current or last frame

Behaviour:
- Reset values:
  - state = IDLE;
  - ld_ready, mem_en, mem_we, busy, done, err_count, err_timeout = 0;
  - win_rst_n = 0;
  - mem_addr, mem_din, win_count = 0.
- IDLE:
  - ld_ready = 0 and win_rst_n = 0.
  - On start: clear win_count, err_count and err_timeout; reset the write address to 0; go to LOAD.
- LOAD:
  - ld_ready = 1 (combinational, state-based).
  - Each ld_valid&&ld_ready beat registers mem_en=1, mem_we=1, mem_addr=wr_addr, mem_din=ld_data on the next cycle; then wr_addr increments.
  - The beat with wr_addr == IMG_W*IMG_H-1 transitions to RUN. Its write still issues in the first RUN cycle.
  - The write mux is selected by the registered write-valid flag, not by state, so this final write is never lost.
- RUN:
  - win_rst_n is registered and rises 1 cycle after RUN entry, i.e. after the final write has issued.
  - When no write is pending: mem_en = win_bram_en, mem_addr = win_bram_addr, mem_we = 0, all combinational.
  - The read path adds zero latency, because the window generator's capture pipeline assumes a direct BRAM connection.
  - win_count increments on every cycle where win_o_valid = 1.
  - The watchdog counter resets on win_o_valid and on RUN entry. When it reaches TIMEOUT: set err_timeout and go to DONE.
  - On win_frame_done: go to DONE, and set err_count if win_count (including a same-cycle increment) != IMG_W*IMG_H.
- DONE:
  - win_rst_n = 0 (registered), done = 1 for exactly this one cycle, then go to IDLE.
  - err flags and win_count hold until the next start.
- abort (highest priority, any state):
  - Next state is IDLE and win_rst_n drops the next cycle.
  - Pending loader beats are dropped, mem_we is forced to 0 that cycle, and done is not pulsed.
- Simultaneous events:
  - start in a non-IDLE state is ignored.
  - start together with abort: abort wins.
  - win_frame_done together with a timeout: the frame_done path is taken and err_timeout stays 0.
- Loader beats offered outside LOAD are stalled (ld_ready = 0) and never written.
- Async reset mid-frame returns every register to its reset value immediately.

Test Plan:
- IMG_W=4, IMG_H=3; start, then 12 continuous ld_valid beats with data 0x000001..0x00000C -> mem writes addr 0..11 with matching data, one per cycle; state enters RUN after beat 12; win_rst_n rises 1 cycle after the 12th write.
- Same frame; model the window generator emitting 12 win_o_valid and then win_frame_done -> done pulses once, win_count=12, err_count=0, busy falls the next cycle.
- Window model emits 11 windows and then win_frame_done -> err_count=1, done pulses, win_count=11.
- TIMEOUT=16; window model never asserts win_o_valid -> err_timeout=1 on RUN cycle 16, done pulses, win_rst_n=0.
- abort on the 6th loader beat -> no further writes, ld_ready=0 the next cycle, done never pulses; a new start rewrites from address 0.
- In RUN, drive win_bram_addr=7 with win_bram_en=1 -> mem_addr=7 and mem_en=1 in the same cycle with mem_we=0; ld_valid held high -> ld_ready stays 0.
